// File: rtl/swarm_runtime_config.sv
// Runtime configuration register file with per-tile broadcast of every
// accepted config write. Holds a VERSION/STATUS/ERR_COUNT read-only window
// at addresses 0..2 and read/write config registers above that.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting writes; wready high (outside reset)
// BCAST | last config write being offered to every tile until all ack
module swarm_runtime_config #(
    parameter int N_TILES    = 1,
    parameter int N_REGS     = 16,
    parameter int DATA_WIDTH = 32,
    parameter int VERSION    = 10,
    parameter logic [N_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [7:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [7:0]            araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [N_TILES-1:0]    cfg_valid,
    input  logic [N_TILES-1:0]    cfg_ready,
    output logic [7:0]            cfg_addr,
    output logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  busy
);

    localparam int         IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [8:0] REG_LIMIT = 9'(N_REGS);
    localparam logic [8:0] FIRST_RW  = 9'd3;

    typedef enum logic {IDLE, BCAST} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [N_TILES-1:0]    pending;
    logic [N_TILES-1:0]    pending_nxt;
    logic                  wr_fire;
    logic                  wr_is_rw;
    logic                  bcast_done;
    logic [DATA_WIDTH-1:0] cfg_regs [N_REGS];
    logic [DATA_WIDTH-1:0] err_count;
    logic [15:0]           bcast_count;
    logic [31:0]           status_raw;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] rd_value;

    assign wr_is_rw    = ({1'b0, waddr} >= FIRST_RW) && ({1'b0, waddr} < REG_LIMIT);
    assign status_raw  = {bcast_count, 15'b0, busy};
    assign status_word = DATA_WIDTH'(status_raw);
    assign arready     = !rvalid;

    // State and pending-mask register; reset drops any broadcast in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // Next state, pending clear on per-tile handshake, and handshake outputs.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        wready      = 1'b0;
        wr_fire     = 1'b0;
        busy        = 1'b0;
        cfg_valid   = '0;
        bcast_done  = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rstn so no write is advertised while reset is held.
                wready  = rstn;
                wr_fire = wvalid && rstn;
                if (wr_fire && wr_is_rw) begin
                    pending_nxt = '1;
                    state_nxt   = BCAST;
                end
            end
            BCAST: begin
                busy        = 1'b1;
                cfg_valid   = pending;
                pending_nxt = pending & ~cfg_ready;
                if (pending_nxt == '0) begin
                    bcast_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config storage, broadcast payload latch, error and broadcast counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REGS; i++) begin
                cfg_regs[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
            cfg_addr    <= '0;
            cfg_data    <= '0;
            err_count   <= '0;
            bcast_count <= '0;
        end else begin
            if (wr_fire && wr_is_rw) begin
                cfg_regs[waddr[IDX_W-1:0]] <= wdata;
                cfg_addr                   <= waddr;
                cfg_data                   <= wdata;
            end else if (wr_fire && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (bcast_done) begin
                bcast_count <= bcast_count + 16'd1;
            end
        end
    end

    // Read mux sees pre-edge values, so a same-cycle write or broadcast
    // completion is not yet visible in the returned data.
    always_comb begin
        rd_value = '0;
        if ({1'b0, araddr} < REG_LIMIT) begin
            case (araddr)
                8'd0:    rd_value = DATA_WIDTH'(VERSION);
                8'd1:    rd_value = status_word;
                8'd2:    rd_value = err_count;
                default: rd_value = cfg_regs[araddr[IDX_W-1:0]];
            endcase
        end
    end

    // Single-entry read response, held until the consumer takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_value;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_swarm_runtime_config.sv
// Self-checking bench for swarm_runtime_config with four tiles and a
// non-zero reset image, compared against a behavioural register model.
module tb_swarm_runtime_config;

    function automatic logic [31:0] rv_of(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h101;
    endfunction

    function automatic logic [511:0] mk_rv();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = rv_of(i);
        return r;
    endfunction

    localparam logic [511:0] RV = mk_rv();

    logic        clk;
    logic        rstn;
    logic        wvalid;
    logic        wready;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        arvalid;
    logic        arready;
    logic [7:0]  araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [3:0]  cfg_valid;
    logic [3:0]  cfg_ready;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [16];
    int unsigned m_err;
    int unsigned m_bcast;

    swarm_runtime_config #(
        .N_TILES(4), .N_REGS(16), .DATA_WIDTH(32), .VERSION(10), .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = rv_of(i);
        m_err   = 0;
        m_bcast = 0;
    endtask

    // Expected read data when the block is idle.
    function automatic logic [31:0] m_read(logic [7:0] a);
        if (a >= 8'd16) return 32'd0;
        case (a)
            8'd0:    return 32'd10;
            8'd1:    return {m_bcast[15:0], 15'b0, 1'b0};
            8'd2:    return m_err;
            default: return m_regs[a[3:0]];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 'x when the response does not arrive exactly one cycle after acceptance.
    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        d       = 'x;
        arvalid = 1'b1;
        araddr  = a;
        rready  = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        if (rvalid === 1'b1) d = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, output logic ok);
        int n;
        wvalid = 1'b1;
        waddr  = a;
        wdata  = d;
        n = 0;
        while (!wready && n < 20) begin
            tick();
            n++;
        end
        ok = wready;
        tick();
        wvalid = 1'b0;
    endtask

    // One broadcast; ack[t] is the BCAST cycle (1-based) in which tile t acks.
    task automatic run_bcast(input logic [7:0] a, input logic [31:0] d,
                             input int ack[4], input bit probe);
        logic        ok;
        logic [3:0]  e;
        int          maxc;
        int unsigned old_cnt;
        maxc = 1;
        for (int t = 0; t < 4; t++) if (ack[t] > maxc) maxc = ack[t];
        do_write(a, d, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bc_wready: got %b want 1", ok); end
        m_regs[a[3:0]] = d;
        old_cnt = m_bcast;
        for (int c = 1; c <= maxc; c++) begin
            for (int t = 0; t < 4; t++) e[t] = (ack[t] >= c);
            n_checks++; if (cfg_valid !== e) begin n_fail++; $display("FAIL bc_valid c%0d: got %b want %b", c, cfg_valid, e); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bc_busy c%0d: got %b want 1", c, busy); end
            n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL bc_wready_low c%0d: got %b want 0", c, wready); end
            n_checks++; if (cfg_addr !== a || cfg_data !== d) begin n_fail++; $display("FAIL bc_payload c%0d: got %h/%h want %h/%h", c, cfg_addr, cfg_data, a, d); end
            for (int t = 0; t < 4; t++) cfg_ready[t] = (ack[t] == c);
            if (probe && c == maxc) begin
                arvalid = 1'b1;
                araddr  = 8'd1;
                rready  = 1'b0;
            end
            tick();
            arvalid = 1'b0;
        end
        cfg_ready = '0;
        m_bcast++;
        n_checks++; if (busy !== 1'b0 || cfg_valid !== 4'b0) begin n_fail++; $display("FAIL bc_done: got busy=%b valid=%b want 0/0", busy, cfg_valid); end
        n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL bc_wready_back: got %b want 1", wready); end
        if (probe) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== {old_cnt[15:0], 15'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bc_status_probe: got v=%b %h want 1 %h", rvalid, rdata, {old_cnt[15:0], 15'b0, 1'b1});
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b1; wvalid = 0; waddr = 0; wdata = 0; arvalid = 0; araddr = 0;
        rready = 0; cfg_ready = '0;
        #3;
        rstn = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b want 0", wready); end
        n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready: got %b want 1", arready); end
        n_checks++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin n_fail++; $display("FAIL rst_read: got %b %h want 0 0", rvalid, rdata); end
        n_checks++; if (cfg_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_cfg: got %b %b want 0 0", cfg_valid, busy); end
        n_checks++; if (cfg_addr !== 8'd0 || cfg_data !== 32'd0) begin n_fail++; $display("FAIL rst_payload: got %h %h want 0 0", cfg_addr, cfg_data); end
        rstn = 1'b1;
        #1;
        n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL rst_release_wready: got %b want 1", wready); end
        model_reset();
        tick();
        do_read(8'd0, d);
        n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL rst_version: got %h want %h", d, 32'd10); end
        do_read(8'd1, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_status: got %h want 0", d); end
        do_read(8'd3, d);
        n_checks++; if (d !== rv_of(3)) begin n_fail++; $display("FAIL rst_reg3: got %h want %h", d, rv_of(3)); end
    endtask

    task automatic test_bcast_acks();
        int          acks[4];
        logic [31:0] d;
        acks = '{1, 3, 3, 6};
        run_bcast(8'd5, 32'hA5A5_A5A5, acks, 1'b0);
        do_read(8'd1, d);
        n_checks++; if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL acks_status: got %h want 00010000", d); end
        do_read(8'd5, d);
        n_checks++; if (d !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL acks_reg5: got %h want a5a5a5a5", d); end
    endtask

    task automatic test_errors();
        logic        ok;
        logic [31:0] d;
        do_write(8'd0, $urandom, ok);
        n_checks++; if (ok !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_w0: got ok=%b busy=%b want 1 0", ok, busy); end
        m_err++;
        do_write(8'd200, $urandom, ok);
        n_checks++; if (ok !== 1'b1 || busy !== 1'b0 || cfg_valid !== 4'b0) begin n_fail++; $display("FAIL err_w200: got ok=%b busy=%b valid=%b want 1 0 0", ok, busy, cfg_valid); end
        m_err++;
        do_read(8'd2, d);
        n_checks++; if (d !== 32'd2 || d !== m_read(8'd2)) begin n_fail++; $display("FAIL err_count: got %h want 2", d); end
        do_read(8'd0, d);
        n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL err_version: got %h want a", d); end
        do_read(8'd200, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL err_oob_read: got %h want 0", d); end
        do_read(8'd2, d);
        n_checks++; if (d !== m_read(8'd2)) begin n_fail++; $display("FAIL err_count_after_read: got %h want %h", d, m_read(8'd2)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, d;
        d1 = $urandom;
        d2 = $urandom;
        wvalid = 1'b1; waddr = 8'd9; wdata = d1;
        tick();
        waddr = 8'd12; wdata = d2;
        for (int c = 1; c <= 2; c++) begin
            n_checks++; if (wready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_hold c%0d: got wready=%b busy=%b want 0 1", c, wready, busy); end
            cfg_ready = (c == 2) ? 4'hF : 4'h0;
            tick();
        end
        cfg_ready = '0;
        m_regs[9] = d1;
        m_bcast++;
        n_checks++; if (wready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got wready=%b busy=%b want 1 0", wready, busy); end
        tick();
        wvalid = 1'b0;
        n_checks++; if (busy !== 1'b1 || cfg_addr !== 8'd12 || cfg_data !== d2) begin n_fail++; $display("FAIL b2b_second: got busy=%b %h %h want 1 0c %h", busy, cfg_addr, cfg_data, d2); end
        cfg_ready = 4'hF;
        tick();
        cfg_ready = '0;
        m_regs[12] = d2;
        m_bcast++;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got busy=%b want 0", busy); end
        do_read(8'd1, d);
        n_checks++; if (d !== m_read(8'd1)) begin n_fail++; $display("FAIL b2b_status: got %h want %h", d, m_read(8'd1)); end
        do_read(8'd9, d);
        n_checks++; if (d !== d1) begin n_fail++; $display("FAIL b2b_reg9: got %h want %h", d, d1); end
    endtask

    task automatic test_status_probe();
        int acks[4];
        acks = '{2, 1, 4, 3};
        run_bcast(8'd4, $urandom, acks, 1'b1);
    endtask

    task automatic test_read_stall();
        logic [31:0] d0;
        arvalid = 1'b1; araddr = 8'd5; rready = 1'b0;
        tick();
        araddr = 8'd3;
        d0 = rdata;
        n_checks++; if (d0 !== m_read(8'd5)) begin n_fail++; $display("FAIL stall_first: got %h want %h", d0, m_read(8'd5)); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got v=%b %h ar=%b want 1 %h 0", c, rvalid, rdata, arready, d0);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got v=%b ar=%b want 0 1", rvalid, arready); end
        tick();
        arvalid = 1'b0;
        n_checks++; if (rvalid !== 1'b1 || rdata !== m_read(8'd3)) begin n_fail++; $display("FAIL stall_next: got v=%b %h want 1 %h", rvalid, rdata, m_read(8'd3)); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset_mid_bcast();
        logic        ok;
        logic [31:0] d;
        do_write(8'd7, 32'h1234_5678, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_write: got %b want 1", ok); end
        cfg_ready = 4'b0001;
        tick();
        cfg_ready = 4'b0010;
        tick();
        cfg_ready = '0;
        n_checks++; if (cfg_valid !== 4'b1100) begin n_fail++; $display("FAIL rmid_partial: got %b want 1100", cfg_valid); end
        rstn = 1'b0;
        #1;
        n_checks++; if (cfg_valid !== 4'b0 || busy !== 1'b0 || wready !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got valid=%b busy=%b wready=%b want 0 0 0", cfg_valid, busy, wready); end
        tick(); tick();
        n_checks++; if (cfg_valid !== 4'b0) begin n_fail++; $display("FAIL rmid_held: got %b want 0", cfg_valid); end
        rstn = 1'b1;
        model_reset();
        tick();
        n_checks++; if (cfg_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %b %b want 0 0", cfg_valid, busy); end
        do_read(8'd7, d);
        n_checks++; if (d !== rv_of(7)) begin n_fail++; $display("FAIL rmid_reg7: got %h want %h", d, rv_of(7)); end
        do_read(8'd1, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rmid_status: got %h want 0", d); end
    endtask

    task automatic test_random();
        logic        ok;
        logic [7:0]  a;
        logic [31:0] d;
        int          acks[4];
        for (int it = 0; it < 12; it++) begin
            a = 8'($urandom_range(0, 20));
            if (a >= 8'd3 && a < 8'd16) begin
                for (int t = 0; t < 4; t++) acks[t] = $urandom_range(1, 5);
                run_bcast(a, $urandom, acks, 1'($urandom_range(0, 1)));
            end else begin
                do_write(a, $urandom, ok);
                m_err++;
                n_checks++; if (ok !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_err_write a=%0d: got ok=%b busy=%b want 1 0", a, ok, busy); end
            end
            a = 8'($urandom_range(0, 20));
            do_read(a, d);
            n_checks++; if (d !== m_read(a)) begin n_fail++; $display("FAIL rnd_read a=%0d: got %h want %h", a, d, m_read(a)); end
        end
    endtask

    initial begin
        test_reset();
        test_bcast_acks();
        test_errors();
        test_back_to_back();
        test_status_probe();
        test_read_stall();
        test_reset_mid_bcast();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/swarm_runtime_config.md
SWARM_RUNTIME_CONFIG -- requirements
Module: swarm_runtime_config

Interface
REQ-001 SHALL have parameter N_TILES, default 1: number of tile config ports (1..16).
REQ-002 SHALL have parameter N_REGS, default 16: register count, addresses 0..N_REGS-1 (4..256).
REQ-003 SHALL have parameter DATA_WIDTH, default 32: register width.
REQ-004 SHALL have parameter VERSION, default 10: constant returned at address 0.
REQ-005 SHALL have parameter RESET_VALUES, default all-zero: packed N_REGS*DATA_WIDTH reset image; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- wvalid / wready  in / out  1 / 1  write request handshake.
- waddr / wdata  in / in  8 / DATA_WIDTH  write address and data.
- arvalid / arready  in / out  1 / 1  read request handshake.
- araddr  in  8  read address.
- rvalid / rready  out / in  1 / 1  read response handshake.
- rdata  out  DATA_WIDTH  read data.
- cfg_valid / cfg_ready  out / in  N_TILES / N_TILES  per-tile broadcast handshake.
- cfg_addr / cfg_data  out / out  8 / DATA_WIDTH  shared broadcast payload.
- busy  out  1  broadcast in progress.

Function
REQ-007 Address map SHALL be: 0 VERSION (RO); 1 STATUS (RO); 2 ERR_COUNT (RO); 3..N_REGS-1 config (RW).
REQ-008 STATUS SHALL be {bcast_count[15:0], 15'b0, busy}, zero-extended or truncated to DATA_WIDTH.
REQ-009 FSM SHALL have two states, IDLE and BCAST; reset state is IDLE.
REQ-010 wready SHALL be 1 exactly in IDLE; a write is accepted on the cycle wvalid&&wready.
REQ-011 An accepted write to a RW address SHALL update the register on the same edge, latch cfg_addr/cfg_data, set the pending mask to all N_TILES ones, and move to BCAST.
REQ-012 An accepted write to a RO or out-of-range address SHALL leave all registers unchanged, increment ERR_COUNT (saturating at all-ones), and stay in IDLE.
REQ-013 In BCAST, cfg_valid[t] SHALL equal pending[t]; pending[t] clears on the edge where cfg_valid[t]&&cfg_ready[t].
REQ-014 cfg_addr/cfg_data SHALL be stable from entry to exit of BCAST.
REQ-015 BCAST SHALL return to IDLE on the edge that clears the last pending bit; bcast_count increments (wrapping at 2^16) on that same edge.
REQ-016 A single-tile broadcast with cfg_ready=1 SHALL take exactly one BCAST cycle; wready returns high the cycle after.
REQ-017 busy SHALL equal (state==BCAST).
REQ-018 arready SHALL equal !rvalid, independent of FSM state.
REQ-019 On arvalid&&arready, rdata SHALL be registered and rvalid asserted next cycle (1-cycle latency).
REQ-020 rvalid and rdata SHALL hold until rvalid&&rready.
REQ-021 A read of an out-of-range address SHALL return 0 and SHALL NOT increment ERR_COUNT.
REQ-022 A read and a write to the same address accepted on the same cycle SHALL return the pre-write value.
REQ-023 A STATUS read in the cycle a broadcast completes SHALL return busy=1 and the pre-increment count.

Reset
REQ-024 While rstn=0 the block SHALL reset:
- State to IDLE.
- Register i to RESET_VALUES slice i.
- ERR_COUNT, bcast_count and pending to 0.
- Outputs: rvalid=0, rdata=0, cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0.
- wready=0 while held, 1 after release; arready=1.
REQ-025 Reset asserted mid-broadcast SHALL abort the broadcast immediately, with no further cfg_valid, and SHALL restore the register to its RESET_VALUES slice.

Verification
REQ-026 Reset with N_TILES=4, then read addr 0, 1 and 3 -> 10, 0, and the RESET_VALUES slice 3.
REQ-027 Write addr 5=0xA5A5A5A5; tiles ack in cycles 1, 3, 3, 6 after BCAST entry -> each cfg_valid drops after its ack; busy low after the cycle-6 ack; STATUS=0x00010000; addr 5 reads 0xA5A5A5A5.
REQ-028 Write addr 0 and addr 200 with N_REGS=16 -> no broadcast; ERR_COUNT=2; VERSION unchanged; addr 200 reads 0.
REQ-029 Issue a second write during BCAST -> wready=0 until completion, then accepted; bcast_count=2 after both complete.
REQ-030 Hold rready=0 for 5 cycles after a read -> rvalid/rdata stable and arready=0 for those cycles; the next read is accepted the cycle after rready=1.
REQ-031 Assert rstn low mid-BCAST with 2 of 4 tiles acked -> cfg_valid=0 at once; the register reads its reset value after reset is released.
